// File: rtl/fifo36_to_gpif_nwide.sv
// Adapts a 36-bit line stream to a 16/32-bit FWFT word buffer for the GPIF/GPMC state machine.
// Optional build macro: GPIF_PKT_FLUSH_EN (has_data also asserts while any eof word is buffered).
module fifo36_to_gpif_nwide #(
  parameter int OUT_WIDTH = 16,
  parameter int FIFO_SIZE = 9,
  parameter int MIN_OCC   = 2,
  parameter bit LE        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [35:0]          in_data,
  input  logic                 in_src_rdy,
  output logic                 in_dst_rdy,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 sof,
  output logic                 eof,
  output logic                 valid,
  input  logic                 enable,
  output logic                 has_data,
  output logic [15:0]          occupied
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int ENTRY_W = OUT_WIDTH + 2;

  typedef enum logic [1:0] {
    HOLD_EMPTY,
    HOLD_FIRST,
    HOLD_SECOND
  } hold_state_t;

  hold_state_t state, state_next;

  logic [31:0]          hold_data;
  logic                 hold_sof;
  logic                 hold_eof;
  logic [1:0]           hold_occ;
  logic                 flush;
  logic                 single_word;
  logic                 last_word;
  logic                 full;
  logic                 write_en;
  logic                 pop;
  logic                 accept;
  logic [15:0]          first_half;
  logic [15:0]          second_half;
  logic [31:0]          word_data;
  logic                 word_sof;
  logic                 word_eof;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   head;
  logic [ENTRY_W-1:0]   mem [0:DEPTH-1];
  logic [FIFO_SIZE-1:0] wr_ptr;
  logic [FIFO_SIZE-1:0] rd_ptr;
  logic [FIFO_SIZE:0]   count;
  logic                 has_data_next;

  assign flush = reset | clear;

  // count tops out at exactly DEPTH, so its MSB alone marks a full buffer
  assign full        = count[FIFO_SIZE];
  assign single_word = (OUT_WIDTH == 32) || (hold_eof && ((hold_occ == 2'd1) || (hold_occ == 2'd2)));
  assign write_en    = (state != HOLD_EMPTY) && !full;
  assign last_word   = (state == HOLD_SECOND) || ((state == HOLD_FIRST) && single_word);
  assign in_dst_rdy  = !flush && ((state == HOLD_EMPTY) || (write_en && last_word));
  assign accept      = in_src_rdy && in_dst_rdy;
  assign valid       = (count != '0);
  assign pop         = valid && enable;

  assign first_half  = LE ? hold_data[15:0]  : hold_data[31:16];
  assign second_half = LE ? hold_data[31:16] : hold_data[15:0];

  always_comb begin
    state_next = state;
    word_data  = '0;
    word_sof   = 1'b0;
    word_eof   = 1'b0;

    if (OUT_WIDTH == 32)
      word_data = hold_data;
    else if (state == HOLD_SECOND)
      word_data = {16'h0000, second_half};
    else
      word_data = {16'h0000, first_half};

    word_sof = hold_sof && (state == HOLD_FIRST);
    word_eof = hold_eof && last_word;

    case (state)
      HOLD_EMPTY: begin
        if (accept)
          state_next = HOLD_FIRST;
      end
      HOLD_FIRST: begin
        if (write_en) begin
          if (last_word)
            state_next = accept ? HOLD_FIRST : HOLD_EMPTY;
          else
            state_next = HOLD_SECOND;
        end
      end
      HOLD_SECOND: begin
        if (write_en)
          state_next = accept ? HOLD_FIRST : HOLD_EMPTY;
      end
      default: state_next = HOLD_EMPTY;
    endcase
  end

  assign wr_entry = {word_eof, word_sof, word_data[OUT_WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (flush)
      state <= HOLD_EMPTY;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      hold_data <= '0;
      hold_sof  <= 1'b0;
      hold_eof  <= 1'b0;
      hold_occ  <= '0;
    end else if (accept) begin
      hold_data <= in_data[31:0];
      hold_sof  <= in_data[32];
      hold_eof  <= in_data[33];
      hold_occ  <= in_data[35:34];
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !flush)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({write_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef GPIF_PKT_FLUSH_EN
  logic [FIFO_SIZE:0] eof_count;
  logic               eof_in;
  logic               eof_out;

  assign eof_in  = write_en && word_eof;
  assign eof_out = pop && head[OUT_WIDTH+1];

  always_ff @(posedge clk) begin
    if (flush)
      eof_count <= '0;
    else begin
      case ({eof_in, eof_out})
        2'b10:   eof_count <= eof_count + 1'b1;
        2'b01:   eof_count <= eof_count - 1'b1;
        default: eof_count <= eof_count;
      endcase
    end
  end

  // a buffered eof lets a short packet drain even below the burst threshold
  assign has_data_next = (32'(count) >= MIN_OCC) || (eof_count != '0);
`else
  assign has_data_next = (32'(count) >= MIN_OCC);
`endif

  always_ff @(posedge clk) begin
    if (flush)
      has_data <= 1'b0;
    else
      has_data <= has_data_next;
  end

  assign head     = mem[rd_ptr];
  assign out_data = valid ? head[OUT_WIDTH-1:0] : '0;
  assign sof      = valid && head[OUT_WIDTH];
  assign eof      = valid && head[OUT_WIDTH+1];
  assign occupied = 16'(count);

endmodule

// File: tb/tb_fifo36_to_gpif_nwide.sv
// Directed bench: a 16-bit LE instance with a 4-word buffer and a 32-bit pass-mode instance.
module tb_fifo36_to_gpif_nwide;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [35:0] in_data;
  logic        in_src_rdy;
  logic        in_dst_rdy;
  logic [15:0] out_data;
  logic        sof;
  logic        eof;
  logic        valid;
  logic        enable;
  logic        has_data;
  logic [15:0] occupied;

  logic [35:0] b_in_data;
  logic        b_in_src_rdy;
  logic        b_in_dst_rdy;
  logic [31:0] b_out_data;
  logic        b_sof;
  logic        b_eof;
  logic        b_valid;
  logic        b_enable;
  logic        b_has_data;
  logic [15:0] b_occupied;

  int vectors = 0;
  int miscompares = 0;

  logic [35:0] lines [3];
  logic [15:0] exp_words [6];

  fifo36_to_gpif_nwide #(.OUT_WIDTH(16), .FIFO_SIZE(2), .MIN_OCC(2), .LE(1'b1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_src_rdy(in_src_rdy),
    .in_dst_rdy(in_dst_rdy), .out_data(out_data), .sof(sof), .eof(eof), .valid(valid),
    .enable(enable), .has_data(has_data), .occupied(occupied)
  );

  fifo36_to_gpif_nwide #(.OUT_WIDTH(32), .FIFO_SIZE(2), .MIN_OCC(2), .LE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_data(b_in_data), .in_src_rdy(b_in_src_rdy),
    .in_dst_rdy(b_in_dst_rdy), .out_data(b_out_data), .sof(b_sof), .eof(b_eof), .valid(b_valid),
    .enable(b_enable), .has_data(b_has_data), .occupied(b_occupied)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [35:0] d);
    int waited = 0;
    in_data = d;
    in_src_rdy = 1'b1;
    while (!in_dst_rdy && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      vectors++; miscompares++;
      $display("[TB] FAIL send_timeout: in_dst_rdy got 0 required 1 for line %h", d);
    end else begin
      tick();
    end
    in_src_rdy = 1'b0;
  endtask

  task automatic send_b(input logic [35:0] d);
    int waited = 0;
    b_in_data = d;
    b_in_src_rdy = 1'b1;
    while (!b_in_dst_rdy && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      vectors++; miscompares++;
      $display("[TB] FAIL send_b_timeout: b_in_dst_rdy got 0 required 1 for line %h", d);
    end else begin
      tick();
    end
    b_in_src_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_data = '0; in_src_rdy = 1'b0; enable = 1'b0;
    b_in_data = '0; b_in_src_rdy = 1'b0; b_enable = 1'b0;
    tick(); tick();
    vectors++; if (in_dst_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dst_rdy: got %b required 0", in_dst_rdy); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b required 0", valid); end
    vectors++; if (occupied !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_occupied: got %0d required 0", occupied); end
    vectors++; if (has_data !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_has_data: got %b required 0", has_data); end
    vectors++; if ({out_data, sof, eof} !== 18'd0) begin miscompares++; $display("[TB] FAIL rst_outputs: got %h/%b/%b required 0", out_data, sof, eof); end
    vectors++; if (b_in_dst_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_b_dst_rdy: got %b required 0", b_in_dst_rdy); end
    reset = 1'b0;
    #1;
    vectors++; if (in_dst_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_dst_rdy: got %b required 1", in_dst_rdy); end
    vectors++; if (b_in_dst_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_b_dst_rdy: got %b required 1", b_in_dst_rdy); end
  endtask

  task automatic test_split();
    send_line(36'h3_AAAA_BBBB);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL split_latency: valid got %b required 0", valid); end
    vectors++; if (in_dst_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL split_hold_busy: in_dst_rdy got %b required 0", in_dst_rdy); end
    tick();
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'hBBBB, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL split_word0: got v%b %h sof%b eof%b required v1 bbbb sof1 eof0", valid, out_data, sof, eof); end
    tick();
    vectors++; if (occupied !== 16'd2) begin miscompares++; $display("[TB] FAIL split_occ: got %0d required 2", occupied); end
    vectors++; if (has_data !== 1'b0) begin miscompares++; $display("[TB] FAIL split_has_data_lag: got %b required 0", has_data); end
    tick();
    vectors++; if (has_data !== 1'b1) begin miscompares++; $display("[TB] FAIL split_has_data: got %b required 1", has_data); end
    enable = 1'b1;
    tick();
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'hAAAA, 1'b0, 1'b1}) begin miscompares++; $display("[TB] FAIL split_word1: got v%b %h sof%b eof%b required v1 aaaa sof0 eof1", valid, out_data, sof, eof); end
    vectors++; if (occupied !== 16'd1) begin miscompares++; $display("[TB] FAIL split_occ_pop: got %0d required 1", occupied); end
    tick();
    vectors++; if ({valid, occupied} !== {1'b0, 16'd0}) begin miscompares++; $display("[TB] FAIL split_drained: got v%b occ %0d required v0 occ 0", valid, occupied); end
    enable = 1'b0;
  endtask

  task automatic test_trim();
    send_line(36'hA_1234_5678);
    vectors++; if (in_dst_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL trim_dst_rdy: got %b required 1", in_dst_rdy); end
    tick();
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'h5678, 1'b0, 1'b1}) begin miscompares++; $display("[TB] FAIL trim_word: got v%b %h sof%b eof%b required v1 5678 sof0 eof1", valid, out_data, sof, eof); end
    tick();
    vectors++; if (occupied !== 16'd1) begin miscompares++; $display("[TB] FAIL trim_single: occupied got %0d required 1", occupied); end
    enable = 1'b1;
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL trim_drained: valid got %b required 0", valid); end
    enable = 1'b0;
  endtask

  task automatic test_full();
    logic [15:0] exp_occ [6];
    exp_occ = '{16'd4, 16'd3, 16'd3, 16'd3, 16'd2, 16'd1};
    for (int i = 0; i < 3; i++) send_line(lines[i]);
    tick(); tick();
    vectors++; if (occupied !== 16'd4) begin miscompares++; $display("[TB] FAIL full_occ: got %0d required 4", occupied); end
    vectors++; if (in_dst_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_dst_rdy: got %b required 0", in_dst_rdy); end
    vectors++; if (has_data !== 1'b1) begin miscompares++; $display("[TB] FAIL full_has_data: got %b required 1", has_data); end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({valid, out_data, sof, eof, occupied} !== {1'b1, exp_words[i], (i == 0), (i == 5), exp_occ[i]}) begin
        miscompares++;
        $display("[TB] FAIL full_drain[%0d]: got v%b %h sof%b eof%b occ%0d required v1 %h sof%b eof%b occ%0d",
                 i, valid, out_data, sof, eof, occupied, exp_words[i], (i == 0), (i == 5), exp_occ[i]);
      end
      tick();
    end
    vectors++; if ({valid, occupied} !== {1'b0, 16'd0}) begin miscompares++; $display("[TB] FAIL full_empty: got v%b occ %0d required v0 occ 0", valid, occupied); end
    enable = 1'b0;
  endtask

  task automatic test_has_data();
    send_line(36'h7_0000_00CD);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (has_data !== 1'b0) begin miscompares++; $display("[TB] FAIL hd_one_word[%0d]: got %b required 0", i, has_data); end
    end
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'h00CD, 1'b1, 1'b1}) begin miscompares++; $display("[TB] FAIL hd_short_pkt: got v%b %h sof%b eof%b required v1 00cd sof1 eof1", valid, out_data, sof, eof); end
    send_line(36'h1_0002_0001);
    tick(); tick();
    vectors++; if (has_data !== 1'b1) begin miscompares++; $display("[TB] FAIL hd_threshold: got %b required 1", has_data); end
    enable = 1'b1;
    tick(); tick(); tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hd_drained: valid got %b required 0", valid); end
    enable = 1'b0;
  endtask

  task automatic test_clear();
    send_line(lines[0]);
    send_line(lines[1]);
    tick();
    vectors++; if (occupied !== 16'd3) begin miscompares++; $display("[TB] FAIL clr_setup: occupied got %0d required 3", occupied); end
    clear = 1'b1;
    #1;
    vectors++; if (in_dst_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_dst_rdy: got %b required 0", in_dst_rdy); end
    tick();
    clear = 1'b0;
    #1;
    vectors++; if ({valid, has_data, occupied} !== {1'b0, 1'b0, 16'd0}) begin miscompares++; $display("[TB] FAIL clr_flushed: got v%b hd%b occ%0d required v0 hd0 occ0", valid, has_data, occupied); end
    vectors++; if (in_dst_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_ready: got %b required 1", in_dst_rdy); end
    enable = 1'b1;
    send_line(36'h3_BEEF_CAFE);
    tick();
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'hCAFE, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL clr_next0: got v%b %h sof%b eof%b required v1 cafe sof1 eof0", valid, out_data, sof, eof); end
    tick();
    vectors++; if ({valid, out_data, sof, eof} !== {1'b1, 16'hBEEF, 1'b0, 1'b1}) begin miscompares++; $display("[TB] FAIL clr_next1: got v%b %h sof%b eof%b required v1 beef sof0 eof1", valid, out_data, sof, eof); end
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_drained: valid got %b required 0", valid); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) send_line(lines[i]);
      end
      begin
        int waited = 0;
        while (!valid && waited < 10) begin
          tick();
          waited++;
        end
        for (int k = 0; k < 6; k++) begin
          vectors++;
          if ({valid, out_data, occupied} !== {1'b1, exp_words[k], 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL b2b[%0d]: got v%b %h occ%0d required v1 %h occ1", k, valid, out_data, occupied, exp_words[k]);
          end
          tick();
        end
      end
    join
    vectors++; if ({valid, occupied} !== {1'b0, 16'd0}) begin miscompares++; $display("[TB] FAIL b2b_empty: got v%b occ%0d required v0 occ0", valid, occupied); end
    enable = 1'b0;
  endtask

  task automatic test_pass_mode();
    send_b(36'h1_DEAD_BEEF);
    vectors++; if (b_in_dst_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL pass_dst_rdy: got %b required 1", b_in_dst_rdy); end
    send_b(36'hE_0000_0012);
    tick();
    vectors++; if ({b_valid, b_out_data, b_sof, b_eof, b_occupied} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'd2}) begin miscompares++; $display("[TB] FAIL pass_word0: got v%b %h sof%b eof%b occ%0d required v1 deadbeef sof1 eof0 occ2", b_valid, b_out_data, b_sof, b_eof, b_occupied); end
    b_enable = 1'b1;
    tick();
    vectors++; if ({b_valid, b_out_data, b_sof, b_eof} !== {1'b1, 32'h0000_0012, 1'b0, 1'b1}) begin miscompares++; $display("[TB] FAIL pass_word1: got v%b %h sof%b eof%b required v1 00000012 sof0 eof1", b_valid, b_out_data, b_sof, b_eof); end
    vectors++; if (b_has_data !== 1'b1) begin miscompares++; $display("[TB] FAIL pass_has_data: got %b required 1", b_has_data); end
    tick();
    vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_drained: got %b required 0", b_valid); end
    b_enable = 1'b0;
  endtask

  initial begin
    lines = '{36'h1_2222_1111, 36'h0_4444_3333, 36'h2_6666_5555};
    exp_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    $display("[TB] starting fifo36_to_gpif_nwide bench");
    test_reset();
    test_split();
    test_trim();
    test_full();
    test_has_data();
    test_clear();
    test_back_to_back();
    test_pass_mode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
